// File: rtl/hazard_ctrl_pkg.sv
// Shared MIPS decode constants and helpers for the ID-stage hazard controller
// and the forwarding unit.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } state_t;

  // $0 is hard-wired, so a write to it can never create a dependency.
  function automatic logic src_match(input logic [4:0] dest,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (dest != 5'd0) && ((dest == rs) || (uses_rt && (dest == rt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_dest_decode.sv
// Destination register of an in-flight instruction: rd for R-type, rt otherwise.
module dest_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] instru,
  output logic [4:0]  dest
);

  logic unused_bits;

  assign dest = (instru[OP_MSB:OP_LSB] == OP_RTYPE) ? instru[RD_MSB:RD_LSB]
                                                    : instru[RT_MSB:RT_LSB];

  assign unused_bits = ^{instru[RS_MSB:RS_LSB], instru[RD_LSB-1:0]};

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard detection: load-use and branch-operand stalls, branch/jump
// flushes, a two-state stall FSM and stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instru,
  input  logic [31:0]      ex_instru,
  input  logic [31:0]      ex_mem_instru,
  input  logic             c_ex_MemRead,
  input  logic             c_ex_RegWrite,
  input  logic             c_ex_mem_MemRead,
  input  logic             c_ex_mem_RegWrite,
  input  logic             c_id_branch_taken,
  output logic             c_pc_write,
  output logic             c_if_id_write,
  output logic             c_id_ex_bubble,
  output logic             c_if_id_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  state_t           state_q;
  logic [1:0]       remain_q;
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] flush_events_q;

  logic [4:0] ex_dest, ex_mem_dest;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt;
  logic       uses_rt, is_branch, is_jump;
  logic       ex_hit, ex_mem_hit;
  logic [1:0] need;
  logic       stall, flush;
  logic       unused_sigs;

  dest_decode u_ex_dest (
    .instru (ex_instru),
    .dest   (ex_dest)
  );

  dest_decode u_ex_mem_dest (
    .instru (ex_mem_instru),
    .dest   (ex_mem_dest)
  );

  assign id_op     = id_instru[OP_MSB:OP_LSB];
  assign id_rs     = id_instru[RS_MSB:RS_LSB];
  assign id_rt     = id_instru[RT_MSB:RT_LSB];
  assign uses_rt   = id_op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  assign is_branch = (id_op == OP_BEQ) || (id_op == OP_BNE);
  assign is_jump   = (id_op == OP_J);

  assign ex_hit     = src_match(ex_dest, id_rs, id_rt, uses_rt);
  assign ex_mem_hit = src_match(ex_mem_dest, id_rs, id_rt, uses_rt);

  // Later rules only ever raise the count, so the result is the maximum.
  always_comb begin
    // NOTE: default assigned first so every path drives need and no latch is inferred.
    need = 2'd0;
    if (is_branch && c_ex_mem_MemRead && ex_mem_hit) need = 2'd1;
    if (c_ex_MemRead && ex_hit)                      need = 2'd1;
    if (is_branch && c_ex_RegWrite && ex_hit)        need = c_ex_MemRead ? 2'd2 : 2'd1;
  end

  // Branch outcome is not trusted while stalled: its operands are still in flight.
  assign stall = !reset && ((state_q == ST_HOLD) || (need != 2'd0));
  assign flush = !reset && (state_q == ST_RUN) && (need == 2'd0)
               && ((is_branch && c_id_branch_taken) || is_jump);

  assign c_pc_write     = !stall;
  assign c_if_id_write  = !stall;
  assign c_id_ex_bubble = stall;
  assign c_if_id_flush  = flush;
  assign stall_cycles   = stall_cycles_q;
  assign flush_events   = flush_events_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      remain_q       <= 2'd0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (stall) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (flush) flush_events_q <= flush_events_q + CNT_W'(1);
      unique case (state_q)
        ST_RUN: begin
          if (need == 2'd2) begin
            state_q  <= ST_HOLD;
            remain_q <= need - 2'd1;
          end
        end
        ST_HOLD: begin
          if (remain_q <= 2'd1) begin
            state_q  <= ST_RUN;
            remain_q <= 2'd0;
          end else begin
            remain_q <= remain_q - 2'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign unused_sigs = ^{id_instru[RD_MSB:0], c_ex_mem_RegWrite};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle model comparison plus directed
// vectors with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      id_instru, ex_instru, ex_mem_instru;
  logic             c_ex_MemRead, c_ex_RegWrite, c_ex_mem_MemRead, c_ex_mem_RegWrite;
  logic             c_id_branch_taken;
  logic             c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int total = 0;
  int bad   = 0;

  int hold_left = 0;
  int hold_next = 0;
  int m_stalls  = 0;
  int m_flushes = 0;
  bit exp_stall = 1'b0;
  bit exp_flush = 1'b0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .id_instru         (id_instru),
    .ex_instru         (ex_instru),
    .ex_mem_instru     (ex_mem_instru),
    .c_ex_MemRead      (c_ex_MemRead),
    .c_ex_RegWrite     (c_ex_RegWrite),
    .c_ex_mem_MemRead  (c_ex_mem_MemRead),
    .c_ex_mem_RegWrite (c_ex_mem_RegWrite),
    .c_id_branch_taken (c_id_branch_taken),
    .c_pc_write        (c_pc_write),
    .c_if_id_write     (c_if_id_write),
    .c_id_ex_bubble    (c_id_ex_bubble),
    .c_if_id_flush     (c_if_id_flush),
    .stall_cycles      (stall_cycles),
    .flush_events      (flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] J_INS = {6'b000010, 26'h000_0040};

  // ---------------- reference model ----------------
  function automatic int dest_of(input logic [31:0] ins);
    if (ins[31:26] == 6'd0) return int'(ins[15:11]);
    return int'(ins[20:16]);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int required_stalls();
    int srcs[$];
    int op, d_ex, d_exm, n;
    bit br, ex_in, exm_in;
    op = int'(id_instru[31:26]);
    br = (op == 4) || (op == 5);
    srcs.push_back(int'(id_instru[25:21]));
    if (op == 0 || op == 4 || op == 5 || op == 43) srcs.push_back(int'(id_instru[20:16]));
    d_ex   = dest_of(ex_instru);
    d_exm  = dest_of(ex_mem_instru);
    ex_in  = 1'b0;
    exm_in = 1'b0;
    foreach (srcs[i]) begin
      if (d_ex != 0 && srcs[i] == d_ex) ex_in = 1'b1;
      if (d_exm != 0 && srcs[i] == d_exm) exm_in = 1'b1;
    end
    n = 0;
    if (c_ex_MemRead && ex_in) n = max2(n, 1);
    if (br && c_ex_RegWrite && ex_in) n = max2(n, c_ex_MemRead ? 2 : 1);
    if (br && c_ex_mem_MemRead && exm_in) n = max2(n, 1);
    return n;
  endfunction

  always @(negedge clk) begin : compare
    int n, op;
    n  = required_stalls();
    op = int'(id_instru[31:26]);
    if (reset) begin
      exp_stall = 1'b0;
      exp_flush = 1'b0;
      hold_next = 0;
    end else begin
      exp_stall = (hold_left > 0) || (n > 0);
      exp_flush = (hold_left == 0) && (n == 0)
                && ((op == 2) || ((op == 4 || op == 5) && c_id_branch_taken));
      hold_next = (hold_left > 0) ? hold_left - 1 : ((n > 0) ? n - 1 : 0);
    end
    check("cyc_pc_write",    32'(c_pc_write),     32'(!exp_stall));
    check("cyc_if_id_write", 32'(c_if_id_write),  32'(!exp_stall));
    check("cyc_bubble",      32'(c_id_ex_bubble), 32'(exp_stall));
    check("cyc_flush",       32'(c_if_id_flush),  32'(exp_flush));
    check("cyc_stall_cycles", stall_cycles, 32'(m_stalls));
    check("cyc_flush_events", flush_events, 32'(m_flushes));
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_left <= 0;
      m_stalls  <= 0;
      m_flushes <= 0;
    end else begin
      hold_left <= hold_next;
      if (exp_stall) m_stalls  <= m_stalls + 1;
      if (exp_flush) m_flushes <= m_flushes + 1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_in(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] exm,
                        input logic ex_mr, input logic ex_rw, input logic exm_mr,
                        input logic exm_rw, input logic taken);
    id_instru         = id;
    ex_instru         = ex;
    ex_mem_instru     = exm;
    c_ex_MemRead      = ex_mr;
    c_ex_RegWrite     = ex_rw;
    c_ex_mem_MemRead  = exm_mr;
    c_ex_mem_RegWrite = exm_rw;
    c_id_branch_taken = taken;
  endtask

  task automatic step(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] exm,
                      input logic ex_mr, input logic ex_rw, input logic exm_mr,
                      input logic exm_rw, input logic taken);
    @(posedge clk);
    #1;
    set_in(id, ex, exm, ex_mr, ex_rw, exm_mr, exm_rw, taken);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(NOP, NOP, NOP, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_stall(input string name, input logic s);
    check({name, "_pc_write"}, 32'(c_pc_write),     32'(!s));
    check({name, "_if_id_wr"}, 32'(c_if_id_write),  32'(!s));
    check({name, "_bubble"},   32'(c_id_ex_bubble), 32'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a live load-use hazard on the inputs: outputs must stay no-stall.
    reset = 1'b1;
    set_in(r_ins(8, 10, 9), i_ins(6'b100011, 16, 8, 0), NOP, 1, 1, 0, 0, 0);
    #23;
    expect_stall("rst", 1'b0);
    check("rst_flush", 32'(c_if_id_flush), 32'd0);
    check("rst_stall_cnt", stall_cycles, 32'd0);
    set_in(NOP, NOP, NOP, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Load-use: lw $8 in EX, add $9,$8,$10 in ID -> one stall.
    step(r_ins(8, 10, 9), i_ins(6'b100011, 16, 8, 0), NOP, 1, 1, 0, 0, 0);
    at_neg();
    expect_stall("lu", 1'b1);
    idle();
    at_neg();
    expect_stall("lu_after", 1'b0);
    check("lu_stall_cnt", stall_cycles, 32'd1);

    // lw $8 then beq $8,$9 -> two stalls, second ignores inputs (jump + taken).
    step(i_ins(6'b000100, 8, 9, 3), i_ins(6'b100011, 16, 8, 0), NOP, 1, 1, 0, 0, 1);
    at_neg();
    expect_stall("lwbr1", 1'b1);
    check("lwbr1_flush", 32'(c_if_id_flush), 32'd0);
    step(J_INS, NOP, NOP, 0, 0, 0, 0, 1);
    at_neg();
    expect_stall("lwbr2", 1'b1);
    check("lwbr2_flush", 32'(c_if_id_flush), 32'd0);
    idle();
    at_neg();
    expect_stall("lwbr_after", 1'b0);
    check("lwbr_stall_cnt", stall_cycles, 32'd3);

    // addi $9 then bne $9,$10: one stall (taken ignored), then the flush.
    step(i_ins(6'b000101, 9, 10, 4), i_ins(6'b001000, 0, 9, 5), NOP, 0, 1, 0, 0, 1);
    at_neg();
    expect_stall("alubr", 1'b1);
    check("alubr_flush_held", 32'(c_if_id_flush), 32'd0);
    step(i_ins(6'b000101, 9, 10, 4), NOP, i_ins(6'b001000, 0, 9, 5), 0, 0, 0, 1, 1);
    at_neg();
    expect_stall("alubr_go", 1'b0);
    check("alubr_flush", 32'(c_if_id_flush), 32'd1);
    idle();
    at_neg();
    check("alubr_flush_cnt", flush_events, 32'd1);
    check("alubr_stall_cnt", stall_cycles, 32'd4);

    // Destination $0 never matches, even for a load or a $0 source.
    step(r_ins(0, 0, 3), r_ins(1, 2, 0), NOP, 0, 1, 0, 0, 0);
    at_neg();
    expect_stall("zero_alu", 1'b0);
    step(r_ins(0, 0, 3), i_ins(6'b100011, 1, 0, 0), NOP, 1, 1, 0, 0, 0);
    at_neg();
    expect_stall("zero_lw", 1'b0);
    step(J_INS, NOP, NOP, 0, 0, 0, 0, 0);
    at_neg();
    check("jump_flush", 32'(c_if_id_flush), 32'd1);
    idle();
    at_neg();
    check("jump_flush_off", 32'(c_if_id_flush), 32'd0);
    check("jump_flush_cnt", flush_events, 32'd2);

    // sw reads rt; addi writes rt, so a match there is not a source.
    step(i_ins(6'b101011, 6, 5, 0), i_ins(6'b100011, 16, 5, 0), NOP, 1, 1, 0, 0, 0);
    at_neg();
    expect_stall("sw_rt", 1'b1);
    step(i_ins(6'b001000, 5, 7, 1), i_ins(6'b100011, 16, 7, 0), NOP, 1, 1, 0, 0, 0);
    at_neg();
    expect_stall("addi_rt", 1'b0);

    // Load two stages ahead only matters to a branch.
    step(i_ins(6'b000100, 8, 0, 2), NOP, i_ins(6'b100011, 16, 8, 0), 0, 0, 1, 1, 0);
    at_neg();
    expect_stall("exm_br", 1'b1);
    step(r_ins(8, 0, 4), NOP, i_ins(6'b100011, 16, 8, 0), 0, 0, 1, 1, 0);
    at_neg();
    expect_stall("exm_alu", 1'b0);
    check("exm_stall_cnt", stall_cycles, 32'd6);

    // Asynchronous reset in the middle of HOLD.
    step(i_ins(6'b000100, 8, 9, 3), i_ins(6'b100011, 16, 8, 0), NOP, 1, 1, 0, 0, 0);
    at_neg();
    expect_stall("hold_entry", 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    expect_stall("hold_rst", 1'b0);
    check("hold_rst_flush", 32'(c_if_id_flush), 32'd0);
    check("hold_rst_stall_cnt", stall_cycles, 32'd0);
    check("hold_rst_flush_cnt", flush_events, 32'd0);
    at_neg();
    set_in(NOP, NOP, NOP, 0, 0, 0, 0, 0);
    reset = 1'b0;
    at_neg();
    expect_stall("post_rst_run", 1'b0);
    check("post_rst_stall_cnt", stall_cycles, 32'd0);

    at_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
